// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine: controller states, coin values
// and the default price also used by the display logic.
package vend_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam int NICKEL  = 5;
    localparam int DIME    = 10;
    localparam int QUARTER = 25;

    localparam int DEFAULT_PRICE      = 35;
    localparam int DEFAULT_MAX_CREDIT = 95;
    localparam int DEFAULT_CREDIT_W   = 7;

endpackage

// File: rtl/coin_decoder.sv
// Combinational coin decoder: flags a single coin pulse and reports its value
// in cents; simultaneous pulses decode as invalid with value 0.
module coin_decoder
    import vend_pkg::*;
(
    input  logic       nickel_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    output logic       valid_one_hot_o,
    output logic [4:0] value_o
);

    always_comb begin
        valid_one_hot_o = 1'b0;
        value_o         = 5'd0;
        case ({quarter_i, dime_i, nickel_i})
            3'b001: begin
                valid_one_hot_o = 1'b1;
                value_o         = 5'(NICKEL);
            end
            3'b010: begin
                valid_one_hot_o = 1'b1;
                value_o         = 5'(DIME);
            end
            3'b100: begin
                valid_one_hot_o = 1'b1;
                value_o         = 5'(QUARTER);
            end
            default: begin
                valid_one_hot_o = 1'b0;
                value_o         = 5'd0;
            end
        endcase
    end

endmodule

// File: rtl/coin_credit_ctrl.sv
// Coin acceptance and credit controller: accumulates credit, strobes vend at
// the price, then pays change or refunds as dime/nickel pulses gated by disp_ready.
module coin_credit_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = DEFAULT_PRICE,
    parameter int MAX_CREDIT = DEFAULT_MAX_CREDIT,
    parameter int CREDIT_W   = DEFAULT_CREDIT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_nickel,
    input  logic                coin_dime,
    input  logic                coin_quarter,
    input  logic                cancel,
    input  logic                stock_empty,
    input  logic                disp_ready,
    output logic                vend,
    output logic                change_nickel,
    output logic                change_dime,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] MAX_C    = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] DIME_C   = CREDIT_W'(DIME);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(NICKEL);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_q, vend_d;
    logic                busy_q, busy_d;
    logic                reject_q, reject_d;

    logic                one_hot;
    logic [4:0]          coin_value;
    logic                any_coin;
    logic                coin_ok;
    logic                pay_dime;
    logic                pay_nickel;
    logic [CREDIT_W-1:0] credit_plus;

    coin_decoder u_coin_decoder (
        .nickel_i        (coin_nickel),
        .dime_i          (coin_dime),
        .quarter_i       (coin_quarter),
        .valid_one_hot_o (one_hot),
        .value_o         (coin_value)
    );

    // Width holds MAX_CREDIT + a quarter, so the sum never wraps before the limit check.
    assign any_coin    = coin_nickel | coin_dime | coin_quarter;
    assign credit_plus = credit_q + CREDIT_W'(coin_value);
    assign coin_ok     = one_hot & ~stock_empty & ~cancel & (credit_plus <= MAX_C);

    // Payout pulses are the one combinational input-to-output path.
    assign pay_dime   = (state_q == CHANGE) & disp_ready & (credit_q >= DIME_C);
    assign pay_nickel = (state_q == CHANGE) & disp_ready & (credit_q < DIME_C)
                      & (credit_q != '0);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = any_coin;
        case (state_q)
            ACCEPT: begin
                if (coin_ok) begin
                    reject_d = 1'b0;
                    credit_d = credit_plus;
                    if (credit_plus >= PRICE_C) begin
                        state_d = VEND;
                    end
                end else if (cancel && (credit_q != '0)) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q != PRICE_C) ? CHANGE : ACCEPT;
            end
            CHANGE: begin
                if (pay_dime) begin
                    credit_d = credit_q - DIME_C;
                end else if (pay_nickel) begin
                    credit_d = credit_q - NICKEL_C;
                end
                if (credit_d == '0) begin
                    state_d = ACCEPT;
                end
            end
            default: begin
                state_d  = ACCEPT;
                credit_d = '0;
            end
        endcase
        vend_d = (state_d == VEND);
        busy_d = (state_d != ACCEPT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ACCEPT;
            credit_q <= '0;
            vend_q   <= 1'b0;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            vend_q   <= vend_d;
            busy_q   <= busy_d;
            reject_q <= reject_d;
        end
    end

    assign vend          = vend_q;
    assign busy          = busy_q;
    assign coin_reject   = reject_q;
    assign credit        = credit_q;
    assign change_dime   = pay_dime;
    assign change_nickel = pay_nickel;

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Bench for coin_credit_ctrl: directed scenarios plus randomized transactions,
// with payout/reject events checked against a transaction-level credit model.
module tb_coin_credit_ctrl;

    localparam int PRICE = 35;
    localparam int MAXC  = 95;
    localparam int W     = 7;

    localparam logic [1:0] EV_VEND   = 2'd0;
    localparam logic [1:0] EV_DIME   = 2'd1;
    localparam logic [1:0] EV_NICKEL = 2'd2;
    localparam logic [1:0] EV_REJ    = 2'd3;

    typedef struct packed {
        logic [1:0]   kind;
        logic         chk;
        logic [W-1:0] credit;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic coin_nickel = 1'b0, coin_dime = 1'b0, coin_quarter = 1'b0;
    logic cancel = 1'b0, stock_empty = 1'b0, disp_ready = 1'b1;
    logic vend, change_nickel, change_dime, coin_reject, busy;
    logic [W-1:0] credit;

    logic b_nickel = 1'b0, b_dime = 1'b0, b_quarter = 1'b0;
    logic b_vend, b_change_nickel, b_change_dime, b_coin_reject, b_busy;
    logic [W-1:0] b_credit;

    int  n_vec = 0;
    int  n_err = 0;
    int  m_credit = 0;
    bit  mon_en = 1'b0;
    bit  rand_dr = 1'b0;
    int  rem;
    ev_t pay_q[$];
    ev_t rej_q[$];
    ev_t mon_e;
    logic [1:0] mon_k;

    always #5 clk = ~clk;

    coin_credit_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_nickel   (coin_nickel),
        .coin_dime     (coin_dime),
        .coin_quarter  (coin_quarter),
        .cancel        (cancel),
        .stock_empty   (stock_empty),
        .disp_ready    (disp_ready),
        .vend          (vend),
        .change_nickel (change_nickel),
        .change_dime   (change_dime),
        .coin_reject   (coin_reject),
        .credit        (credit),
        .busy          (busy)
    );

    coin_credit_ctrl #(.PRICE(95), .MAX_CREDIT(95), .CREDIT_W(W)) dut95 (
        .clk           (clk),
        .reset         (reset),
        .coin_nickel   (b_nickel),
        .coin_dime     (b_dime),
        .coin_quarter  (b_quarter),
        .cancel        (1'b0),
        .stock_empty   (1'b0),
        .disp_ready    (1'b1),
        .vend          (b_vend),
        .change_nickel (b_change_nickel),
        .change_dime   (b_change_dime),
        .coin_reject   (b_coin_reject),
        .credit        (b_credit),
        .busy          (b_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every payout or reject pulse must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (vend || change_dime || change_nickel) begin
                mon_k = vend ? EV_VEND : (change_dime ? EV_DIME : EV_NICKEL);
                check("single payout pulse", int'(vend) + int'(change_dime) + int'(change_nickel), 1);
                check("payout expected", int'(pay_q.size() > 0), 1);
                if (pay_q.size() > 0) begin
                    mon_e = pay_q.pop_front();
                    check("payout kind", int'(mon_k), int'(mon_e.kind));
                    check("payout credit", int'(credit), int'(mon_e.credit));
                end
            end
            if (coin_reject) begin
                check("reject expected", int'(rej_q.size() > 0), 1);
                if (rej_q.size() > 0) begin
                    mon_e = rej_q.pop_front();
                    if (mon_e.chk) check("reject credit", int'(credit), int'(mon_e.credit));
                end
            end
        end
    end

    task automatic push_ev(input logic [1:0] k, input int c, input bit chk);
        ev_t e;
        e.kind = k;
        e.chk = chk;
        e.credit = W'(c);
        if (k == EV_REJ) rej_q.push_back(e);
        else pay_q.push_back(e);
    endtask

    // Change owed is paid as many dimes as fit, then at most one nickel.
    task automatic push_payout(input int owed);
        for (int i = 0; i < owed / 10; i++) push_ev(EV_DIME, owed - 10 * i, 1'b1);
        if (owed % 10 != 0) push_ev(EV_NICKEL, 5, 1'b1);
    endtask

    task automatic model_txn(input bit n, input bit d, input bit q, input bit se,
                             input bit can, output int vend_rem);
        int cnt;
        int val;
        cnt = int'(n) + int'(d) + int'(q);
        val = n ? 5 : (d ? 10 : (q ? 25 : 0));
        vend_rem = -1;
        if (cnt == 1 && !se && !can && m_credit + val <= MAXC) begin
            m_credit += val;
            if (m_credit >= PRICE) begin
                push_ev(EV_VEND, m_credit, 1'b1);
                vend_rem = m_credit - PRICE;
                push_payout(vend_rem);
                m_credit = 0;
            end
        end else begin
            if (cnt > 0) push_ev(EV_REJ, m_credit, 1'b1);
            if (can && m_credit > 0) begin
                push_payout(m_credit);
                m_credit = 0;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (rand_dr) disp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive(input bit n, input bit d, input bit q, input bit se, input bit can);
        next_cycle();
        coin_nickel = n; coin_dime = d; coin_quarter = q; stock_empty = se; cancel = can;
        next_cycle();
        coin_nickel = 0; coin_dime = 0; coin_quarter = 0; stock_empty = 0; cancel = 0;
    endtask

    task automatic txn(input bit n, input bit d, input bit q, input bit se, input bit can,
                       output int vend_rem);
        model_txn(n, d, q, se, can, vend_rem);
        drive(n, d, q, se, can);
    endtask

    task automatic drive_b(input bit n, input bit d, input bit q);
        next_cycle();
        b_nickel = n; b_dime = d; b_quarter = q;
        next_cycle();
        b_nickel = 0; b_dime = 0; b_quarter = 0;
    endtask

    task automatic settle();
        int i;
        i = 0;
        while (busy && i < 400) begin
            next_cycle();
            i++;
        end
        check("idle within budget", int'(i < 400), 1);
        @(negedge clk);
        #1;
        check("credit at idle", int'(credit), m_credit);
        check("payouts drained", pay_q.size(), 0);
        check("rejects drained", rej_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("reset credit", int'(credit), 0);
        check("reset vend", int'(vend), 0);
        check("reset busy", int'(busy), 0);
        check("reset reject", int'(coin_reject), 0);
        check("reset payout", int'(change_dime) + int'(change_nickel), 0);
        check("reset credit p95", int'(b_credit), 0);
        #10;
        reset = 1'b1;
        mon_en = 1'b1;

        // Exact price: quarter + dime
        txn(0, 0, 1, 0, 0, rem);
        txn(0, 1, 0, 0, 0, rem);
        check("exact vend", int'(vend), 1);
        check("exact credit at vend", int'(credit), 35);
        next_cycle();
        check("exact vend one cycle", int'(vend), 0);
        check("exact credit after", int'(credit), 0);
        check("exact busy falls", int'(busy), 0);
        settle();

        // Vend with 15 change
        txn(0, 0, 1, 0, 0, rem);
        txn(0, 0, 1, 0, 0, rem);
        check("change vend", int'(vend), 1);
        check("change credit at vend", int'(credit), 50);
        next_cycle();
        check("first change dime", int'(change_dime), 1);
        check("credit before dime", int'(credit), 15);
        next_cycle();
        check("then change nickel", int'(change_nickel), 1);
        check("credit before nickel", int'(credit), 5);
        next_cycle();
        check("change done busy", int'(busy), 0);
        settle();

        // Refund, then cancel at zero credit
        txn(0, 1, 0, 0, 0, rem);
        txn(0, 0, 0, 0, 1, rem);
        check("refund dime latency", int'(change_dime), 1);
        check("refund no vend", int'(vend), 0);
        settle();
        txn(0, 0, 0, 0, 1, rem);
        check("cancel at zero busy", int'(busy), 0);
        settle();

        // Rejects
        txn(1, 1, 0, 0, 0, rem);
        check("double coin reject", int'(coin_reject), 1);
        check("double coin credit", int'(credit), 0);
        next_cycle();
        check("reject one cycle", int'(coin_reject), 0);
        txn(0, 0, 1, 1, 0, rem);
        check("stock empty reject", int'(coin_reject), 1);
        check("stock empty credit", int'(credit), 0);
        settle();

        // Stall in CHANGE with credit 15, quarter rejected meanwhile
        txn(0, 0, 1, 0, 0, rem);
        disp_ready = 1'b0;
        txn(0, 0, 1, 0, 0, rem);
        next_cycle();
        check("stall credit held 1", int'(credit), 15);
        check("stall no pulse", int'(change_dime) + int'(change_nickel), 0);
        check("stall busy", int'(busy), 1);
        push_ev(EV_REJ, 15, 1'b1);
        drive(0, 0, 1, 0, 0);
        check("stall quarter reject", int'(coin_reject), 1);
        check("stall credit held 2", int'(credit), 15);
        next_cycle();
        check("stall credit held 3", int'(credit), 15);
        disp_ready = 1'b1;
        #1;
        check("resume dime", int'(change_dime), 1);
        next_cycle();
        check("resume nickel", int'(change_nickel), 1);
        settle();

        // Asynchronous reset during payout
        disp_ready = 1'b0;
        txn(0, 0, 1, 0, 0, rem);
        txn(0, 0, 1, 0, 0, rem);
        next_cycle();
        check("pre-reset credit", int'(credit), 15);
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async reset credit", int'(credit), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset vend/reject", int'(vend) + int'(coin_reject), 0);
        disp_ready = 1'b1;
        #1;
        check("async reset no payout", int'(change_dime) + int'(change_nickel), 0);
        pay_q.delete();
        rej_q.delete();
        m_credit = 0;
        #2;
        reset = 1'b1;
        mon_en = 1'b1;
        txn(1, 0, 0, 0, 0, rem);
        check("post-reset nickel credit", int'(credit), 5);
        check("post-reset no vend", int'(vend), 0);
        settle();

        // Credit ceiling with PRICE = MAX_CREDIT = 95
        drive_b(0, 0, 1);
        drive_b(0, 0, 1);
        drive_b(0, 0, 1);
        drive_b(0, 1, 0);
        check("p95 credit 85", int'(b_credit), 85);
        drive_b(0, 0, 1);
        check("p95 overflow reject", int'(b_coin_reject), 1);
        check("p95 credit held", int'(b_credit), 85);
        check("p95 no vend", int'(b_vend), 0);

        // Randomized transactions with random disp_ready stalls
        rand_dr = 1'b1;
        for (int t = 0; t < 250; t++) begin
            bit n, d, q, se, can;
            int r;
            n = 0; d = 0; q = 0; se = 0; can = 0;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: n = 1;
                2, 3: d = 1;
                4, 5: q = 1;
                6: begin
                    n = 1'($urandom_range(0, 1));
                    d = 1'($urandom_range(0, 1));
                    q = 1;
                end
                7: can = 1;
                8: begin
                    q = 1;
                    se = 1;
                end
                default: begin
                    d = 1;
                    can = 1;
                end
            endcase
            txn(n, d, q, se, can, rem);
            if (rem > 0 && $urandom_range(0, 1) == 1) begin
                push_ev(EV_REJ, 0, 1'b0);
                drive(0, 0, 1, 0, 0);
            end
            settle();
        end
        rand_dr = 1'b0;

        repeat (3) @(negedge clk);
        check("final payouts drained", pay_q.size(), 0);
        check("final rejects drained", rej_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
